// File: rtl/rf_transfer_sequencer.sv
// Register-file transfer micro-sequencer: runs MOV/LDI/INC/ADDR/CLR
// commands by driving one-hot read/write enables of an 11x12 file.
module rf_transfer_sequencer #(
  parameter int REG_COUNT = 11,
  parameter int REG_WIDTH = 12,
  parameter int R_IDX     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [3:0]           cmd_src,
  input  logic [3:0]           cmd_dst,
  input  logic [REG_WIDTH-1:0] cmd_imm,
  output logic [REG_COUNT-1:0] rf_read_en,
  output logic [REG_COUNT-1:0] rf_write_en,
  input  logic [REG_WIDTH-1:0] rf_dataout,
  output logic [REG_WIDTH-1:0] rf_datain,
  output logic                 done,
  output logic                 err,
  output logic                 carry
);

  typedef enum logic [1:0] {
    IDLE,
    RD_A,
    RD_B,
    WRITE
  } state_t;

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_ADDR = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;

  localparam logic [3:0] MAX_IDX = 4'(REG_COUNT - 1);
  localparam logic [REG_COUNT-1:0] ONE = REG_COUNT'(1);

  state_t state;
  state_t state_n;

  logic [2:0]           op_q;
  logic [3:0]           src_q;
  logic [3:0]           dst_q;
  logic [REG_WIDTH-1:0] imm_q;
  logic [REG_WIDTH-1:0] a_q;
  logic [REG_WIDTH-1:0] b_q;

  logic                 accept;
  logic                 src_bad;
  logic                 dst_bad;
  logic                 bad;
  logic [REG_WIDTH-1:0] addend;
  logic [REG_WIDTH:0]   sum;
  logic [REG_WIDTH-1:0] result;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign src_bad   = (cmd_src > MAX_IDX);
  assign dst_bad   = (cmd_dst > MAX_IDX);

  // Only the index fields an op actually uses can reject it
  always_comb begin
    bad = 1'b0;
    unique case (cmd_op)
      OP_MOV, OP_INC, OP_ADDR: bad = src_bad | dst_bad;
      OP_LDI, OP_CLR:          bad = dst_bad;
      default:                 bad = 1'b1;
    endcase
  end

  assign addend = (op_q == OP_ADDR) ? b_q : REG_WIDTH'(1);
  assign sum    = {1'b0, a_q} + {1'b0, addend};

  always_comb begin
    result = '0;
    unique case (op_q)
      OP_MOV:         result = a_q;
      OP_LDI:         result = imm_q;
      OP_INC, OP_ADDR: result = sum[REG_WIDTH-1:0];
      default:        result = '0;
    endcase
  end

  always_comb begin
    state_n     = state;
    rf_read_en  = '0;
    rf_write_en = '0;
    rf_datain   = '0;
    unique case (state)
      IDLE: begin
        if (accept && !bad) begin
          unique case (cmd_op)
            OP_MOV, OP_INC, OP_ADDR: state_n = RD_A;
            default:                 state_n = WRITE;
          endcase
        end
      end
      RD_A: begin
        rf_read_en = ONE << src_q;
        state_n    = (op_q == OP_ADDR) ? RD_B : WRITE;
      end
      RD_B: begin
        rf_read_en = ONE << R_IDX;
        state_n    = WRITE;
      end
      WRITE: begin
        rf_write_en = ONE << dst_q;
        rf_datain   = result;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      carry <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      err   <= 1'b0;
      if (accept) begin
        op_q  <= cmd_op;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
        if (bad) begin
          done <= 1'b1;
          err  <= 1'b1;
        end
      end
      if (state == RD_A) a_q <= rf_dataout;
      if (state == RD_B) b_q <= rf_dataout;
      if (state == WRITE) begin
        done <= 1'b1;
        if (op_q == OP_INC || op_q == OP_ADDR)
          carry <= sum[REG_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rf_transfer_sequencer.sv
// Bench for rf_transfer_sequencer: register-file model plus a
// scoreboard of expected writes/flags checked on every done pulse.
module tb_rf_transfer_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [11:0] cmd_imm;
  logic [10:0] rf_read_en;
  logic [10:0] rf_write_en;
  logic [11:0] rf_dataout;
  logic [11:0] rf_datain;
  logic        done;
  logic        err;
  logic        carry;

  typedef struct packed {
    logic [10:0] we;
    logic [11:0] data;
    logic        err;
    logic        carry;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] rf[11];
  logic        m_carry;
  int          checks;
  int          failures;
  int          cyc;
  logic [10:0] wr_en_s;
  logic [11:0] wr_d_s;

  rf_transfer_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_imm    (cmd_imm),
    .rf_read_en (rf_read_en),
    .rf_write_en(rf_write_en),
    .rf_dataout (rf_dataout),
    .rf_datain  (rf_datain),
    .done       (done),
    .err        (err),
    .carry      (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  always_comb begin
    rf_dataout = '0;
    for (int i = 0; i < 11; i++)
      if (rf_read_en[i]) rf_dataout = rf[i];
  end

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 11; i++)
        if (rf_write_en[i]) rf[i] = rf_datain;
    end
  end

  // Scoreboard monitor: enable sanity every cycle, full compare on done
  initial begin
    exp_t e;
    wr_en_s = '0;
    wr_d_s  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        wr_en_s = '0;
        wr_d_s  = '0;
      end else begin
        checks++;
        if (!$onehot0(rf_read_en) || !$onehot0(rf_write_en) ||
            (rf_write_en == 0 && rf_datain != 0)) begin
          failures++;
          $display("FAIL enables: rd=%h wr=%h din=%0d need one-hot/zero, din=0 off-write",
                   rf_read_en, rf_write_en, rf_datain);
        end
        if (rf_write_en != 0) begin
          wr_en_s = rf_write_en;
          wr_d_s  = rf_datain;
        end
        if (done) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: done seen with no expected entry");
          end else begin
            e = sb.pop_front();
            if (wr_en_s !== e.we || wr_d_s !== e.data ||
                err !== e.err || carry !== e.carry) begin
              failures++;
              $display("FAIL scoreboard: got we=%h d=%0d err=%b c=%b need we=%h d=%0d err=%b c=%b",
                       wr_en_s, wr_d_s, err, carry, e.we, e.data, e.err, e.carry);
            end
          end
          wr_en_s = '0;
          wr_d_s  = '0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] src,
                       input logic [3:0] dst, input logic [11:0] imm,
                       output int acc);
    exp_t        e;
    logic        bad;
    logic [12:0] s;
    int          n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: cmd_ready=%b need 1", cmd_ready);
    end
    bad = (op > 3'd4) || (dst > 4'd10) ||
          ((op == 3'd0 || op == 3'd2 || op == 3'd3) && src > 4'd10);
    e.err = bad;
    e.we  = '0;
    e.data = '0;
    if (!bad) begin
      e.we = 11'd1 << dst;
      case (op)
        3'd0: e.data = rf[src];
        3'd1: e.data = imm;
        3'd2: begin
          s = {1'b0, rf[src]} + 13'd1;
          e.data = s[11:0];
          m_carry = s[12];
        end
        3'd3: begin
          s = {1'b0, rf[src]} + {1'b0, rf[0]};
          e.data = s[11:0];
          m_carry = s[12];
        end
        default: e.data = '0;
      endcase
    end
    e.carry = m_carry;
    sb.push_back(e);
    acc = cyc;
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: pending=%0d need 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (rf_read_en !== 0 || rf_write_en !== 0 || rf_datain !== 0 ||
        done !== 0 || err !== 0 || carry !== 0 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL reset: rd=%h wr=%h din=%0d done=%b err=%b c=%b rdy=%b need zeros, rdy=1",
               rf_read_en, rf_write_en, rf_datain, done, err, carry, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mov();
    int a;
    rf[8] = 12'd900;
    issue(3'd0, 4'd8, 4'd1, 12'd0, a);
    checks++;
    if (rf_read_en !== 11'h100 || rf_write_en !== 0) begin
      failures++;
      $display("FAIL mov_rda: rd=%h wr=%h need 100/000", rf_read_en, rf_write_en);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_write_en !== 11'h002 || rf_datain !== 12'd900 || rf_read_en !== 0 || done !== 0) begin
      failures++;
      $display("FAIL mov_write: wr=%h din=%0d rd=%h done=%b need 002/900/000/0",
               rf_write_en, rf_datain, rf_read_en, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1 || err !== 0 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL mov_done: done=%b err=%b rdy=%b need 1/0/1", done, err, cmd_ready);
    end
    wait_idle();
  endtask

  task automatic test_ldi_addr();
    int a;
    issue(3'd1, 4'd0, 4'd0, 12'd500, a);
    wait_idle();
    rf[9] = 12'd1600;
    issue(3'd3, 4'd9, 4'd9, 12'd0, a);
    checks++;
    if (rf_read_en !== 11'h200) begin
      failures++;
      $display("FAIL addr_rda: rd=%h need 200", rf_read_en);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_read_en !== 11'h001 || rf_write_en !== 0) begin
      failures++;
      $display("FAIL addr_rdb: rd=%h wr=%h need 001/000", rf_read_en, rf_write_en);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_write_en !== 11'h200 || rf_datain !== 12'd2100) begin
      failures++;
      $display("FAIL addr_write: wr=%h din=%0d need 200/2100", rf_write_en, rf_datain);
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    int a;
    rf[9] = 12'd4000;
    rf[0] = 12'd200;
    issue(3'd3, 4'd9, 4'd3, 12'd0, a);
    wait_idle();
    checks++;
    if (carry !== 1'b1 || rf[3] !== 12'd104) begin
      failures++;
      $display("FAIL addr_ovf: c=%b r3=%0d need 1/104", carry, rf[3]);
    end
    issue(3'd0, 4'd3, 4'd4, 12'd0, a);
    wait_idle();
    rf[5] = 12'd5;
    issue(3'd2, 4'd5, 4'd5, 12'd0, a);
    wait_idle();
    checks++;
    if (carry !== 1'b0 || rf[5] !== 12'd6) begin
      failures++;
      $display("FAIL inc_small: c=%b r5=%0d need 0/6", carry, rf[5]);
    end
  endtask

  task automatic test_inc_wrap();
    int a;
    rf[10] = 12'd4095;
    issue(3'd2, 4'd10, 4'd10, 12'd0, a);
    @(posedge clk); #1;
    checks++;
    if (rf_write_en !== 11'h400 || rf_datain !== 12'd0) begin
      failures++;
      $display("FAIL inc_wrap: wr=%h din=%0d need 400/0", rf_write_en, rf_datain);
    end
    wait_idle();
  endtask

  task automatic test_err();
    int a;
    issue(3'd0, 4'd12, 4'd1, 12'd0, a);
    checks++;
    if (done !== 1 || err !== 1 || rf_read_en !== 0 || rf_write_en !== 0 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL err_idx: done=%b err=%b rd=%h wr=%h rdy=%b need 1/1/0/0/1",
               done, err, rf_read_en, rf_write_en, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 0 || err !== 0) begin
      failures++;
      $display("FAIL err_pulse: done=%b err=%b need 0/0", done, err);
    end
    issue(3'd6, 4'd0, 4'd0, 12'd0, a);
    checks++;
    if (done !== 1 || err !== 1 || rf_read_en !== 0 || rf_write_en !== 0) begin
      failures++;
      $display("FAIL err_op: done=%b err=%b rd=%h wr=%h need 1/1/0/0",
               done, err, rf_read_en, rf_write_en);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2, t3, t4, t5;
    issue(3'd1, 4'd0, 4'd2, 12'd7, t0);
    issue(3'd4, 4'd0, 4'd7, 12'd0, t1);
    issue(3'd0, 4'd2, 4'd8, 12'd0, t2);
    issue(3'd2, 4'd8, 4'd8, 12'd0, t3);
    issue(3'd3, 4'd8, 4'd9, 12'd0, t4);
    issue(3'd1, 4'd0, 4'd1, 12'd33, t5);
    wait_idle();
    checks++;
    if (t1 - t0 != 2 || t2 - t1 != 2 || t3 - t2 != 3 || t4 - t3 != 3 || t5 - t4 != 4) begin
      failures++;
      $display("FAIL throughput: gaps=%0d,%0d,%0d,%0d,%0d need 2,2,3,3,4",
               t1 - t0, t2 - t1, t3 - t2, t4 - t3, t5 - t4);
    end
  endtask

  task automatic test_reset_mid_write();
    int a;
    rf[2] = 12'd77;
    rf[6] = 12'd291;
    issue(3'd0, 4'd2, 4'd6, 12'd0, a);
    @(posedge clk); #1;
    checks++;
    if (rf_write_en !== 11'h040 || carry !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: wr=%h c=%b need 040/1", rf_write_en, carry);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (rf_write_en !== 0 || rf_datain !== 0 || carry !== 0 || cmd_ready !== 1 || done !== 0) begin
      failures++;
      $display("FAIL rst_mid: wr=%h din=%0d c=%b rdy=%b done=%b need 0/0/0/1/0",
               rf_write_en, rf_datain, carry, cmd_ready, done);
    end
    sb.delete();
    m_carry = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rf[6] !== 12'd291 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL rst_nowrite: r6=%0d rdy=%b need 291/1", rf[6], cmd_ready);
    end
    issue(3'd1, 4'd0, 4'd6, 12'd42, a);
    wait_idle();
    checks++;
    if (rf[6] !== 12'd42) begin
      failures++;
      $display("FAIL rst_after: r6=%0d need 42", rf[6]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    m_carry = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_imm = '0;
    for (int i = 0; i < 11; i++) rf[i] = '0;
    test_reset();
    test_mov();
    test_ldi_addr();
    test_overflow();
    test_inc_wrap();
    test_err();
    test_back_to_back();
    test_inc_wrap();
    test_reset_mid_write();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
